dl_counter_arb: RTL and testbench

- Round-robin scheduler that shares one interval counter among NUM_REQ requesters.
- Each requester asks for a count of a given length. The arbiter grants one requester at a time and runs the shared counter from 0 up to that requester's target while `en` is high.
- On completion it returns a one-cycle done pulse to the owner.
- Sits in front of timing/delay users in the design library that would otherwise each instantiate their own counter.

---
 rtl/dl_pkg.sv | 10 +
 rtl/dl_rr_arb.sv | 32 +++
 rtl/dl_counter_arb.sv | 127 ++++++++++++
 tb/tb_dl_counter_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types for the design-library counter/arbiter blocks.
package dl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dl_cnt_arb_state_e;

endpackage

// File: rtl/dl_rr_arb.sv
// Combinational round-robin select: first set request strictly after the
// last owner, wrapping modulo NUM_REQ.
module dl_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWN_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWN_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [OWN_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    // Walk offsets 1..NUM_REQ so the last owner is visited last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OWN_W'((int'(last_i) + k) % NUM_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/dl_counter_arb.sv
// Round-robin scheduler sharing one runtime-targeted interval counter among
// NUM_REQ requesters, with a one-cycle done pulse back to the owner.
module dl_counter_arb
  import dl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 5,
  parameter int OWN_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_cnt,
  input  logic                         en,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [OWN_W-1:0]             owner,
  output logic                         busy,
  output logic [NUM_BITS-1:0]          q,
  output logic [NUM_REQ-1:0]           done
);

  dl_cnt_arb_state_e    state_q, state_d;
  logic [NUM_BITS-1:0]  cnt_q, cnt_d;
  logic [NUM_BITS-1:0]  tgt_q, tgt_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic [NUM_REQ-1:0]   sel_oh;
  logic [OWN_W-1:0]     sel_idx;
  logic                 sel_vld;
  logic [NUM_BITS-1:0]  tgt_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tgt
    assign tgt_arr[g] = req_cnt[g*NUM_BITS +: NUM_BITS];
  end

  dl_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (sel_oh),
    .idx_o  (sel_idx),
    .vld_o  (sel_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Target is pure data: only meaningful once latched at grant.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_vld) begin
          tgt_d   = tgt_arr[sel_idx];
          owner_d = sel_idx;
          gnt_d   = sel_oh;
          state_d = RUN;
        end
      end
      RUN: begin
        // A dropped request wins over a same-cycle completion.
        if (!req[owner_q]) begin
          gnt_d   = '0;
          cnt_d   = '0;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (en && (cnt_q == tgt_q)) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          last_d  = owner_q;
          state_d = DONE;
        end else if (en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    gnt   = gnt_q;
    owner = owner_q;
    q     = cnt_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_dl_counter_arb.sv
// Bench for dl_counter_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_dl_counter_arb;

  localparam int N  = 4;
  localparam int NB = 5;
  localparam int OW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*NB-1:0]  req_cnt = '0;
  logic             en = 1'b0;
  logic [N-1:0]     gnt;
  logic [OW-1:0]    owner;
  logic             busy;
  logic [NB-1:0]    q;
  logic [N-1:0]     done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dl_counter_arb #(.NUM_REQ(N), .NUM_BITS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_cnt (req_cnt),
    .en      (en),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .q       (q),
    .done    (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = counting for m_own, 2 = completion cycle.
  int           m_ph, m_own, m_last, m_cnt, m_tgt;
  logic [N-1:0] m_gnt, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_own = 0; m_last = N - 1; m_cnt = 0; m_tgt = 0;
      m_gnt = '0; m_done = '0;
    end else begin
      m_done = '0;
      if (m_ph == 0) begin
        m_cnt = 0;
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last + i) % N;
          if (m_ph == 0 && req[c]) begin
            m_own = c;
            m_tgt = int'(req_cnt[c*NB +: NB]);
            m_gnt = '0;
            m_gnt[c] = 1'b1;
            m_ph = 1;
          end
        end
      end else if (m_ph == 1) begin
        if (!req[m_own]) begin
          m_gnt = '0; m_last = m_own; m_ph = 0; m_cnt = 0;
        end else if (en && m_cnt == m_tgt) begin
          m_gnt = '0; m_done[m_own] = 1'b1; m_last = m_own; m_ph = 2;
        end else if (en) begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0; m_ph = 0;
      end
    end
  end

  logic [N-1:0] prev_gnt = '0;
  int           gq[$];

  always @(posedge clk) begin
    #1;
    chk("gnt",   gnt,   m_gnt);
    chk("done",  done,  m_done);
    chk("q",     q,     m_cnt);
    chk("busy",  busy,  (m_ph != 0));
    chk("owner", owner, m_own);
    if (gnt != '0 && prev_gnt == '0) gq.push_back(int'(owner));
    prev_gnt = gnt;
  end

  task automatic set_tgt(input int i, input int v);
    req_cnt[i*NB +: NB] = v[NB-1:0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_q(input int o, input int v, input int budget, input string nm);
    int  n;
    bit  hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk); #1; n++;
      if (busy && owner == o[OW-1:0] && q == v[NB-1:0]) hit = 1'b1;
    end
    chk(nm, hit, 1);
  endtask

  task automatic wait_done(input int o, input int budget, input string nm);
    int  n;
    bit  hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk); #1; n++;
      if (done[o]) hit = 1'b1;
    end
    chk(nm, hit, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_gnt[6]  = '{1, 1, 1, 1, 0, 0};
    int t1_q[6]    = '{0, 1, 2, 3, 3, 0};
    int t1_done[6] = '{0, 0, 0, 0, 1, 0};
    int t1_busy[6] = '{1, 1, 1, 1, 1, 0};
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int done_k;
    int v;

    // Reset state
    @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_q", q, 0);
    do_reset();

    // Single request, target 3
    set_tgt(0, 3); req = 4'b0001; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_gnt_c%0d", k + 1), gnt, t1_gnt[k]);
      chk($sformatf("t1_q_c%0d", k + 1), q, t1_q[k]);
      chk($sformatf("t1_done_c%0d", k + 1), done, t1_done[k]);
      chk($sformatf("t1_busy_c%0d", k + 1), busy, t1_busy[k]);
      if (k == 4) req = '0;
    end

    // All four request, target 1: round-robin order
    do_reset();
    for (int i = 0; i < N; i++) set_tgt(i, 1);
    gq.delete();
    req = 4'b1111; en = 1'b1;
    repeat (25) @(posedge clk);
    #2;
    req = '0;
    chk("t2_num_grants", (gq.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("t2_order_%0d", i), gq[i], exp_order[i]);

    // Toggling enable, target 4 on requester 1
    do_reset();
    set_tgt(1, 4); req = 4'b0010; en = 1'b1; done_k = -1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done[1] && done_k < 0) begin
        done_k = k;
        req = '0;
      end
      @(negedge clk);
      en = ~en;
    end
    chk("t3_done_edge", done_k, 10);

    // Abort requester 2 at q=2, requester 3 then granted
    do_reset();
    set_tgt(2, 6); set_tgt(3, 1); req = 4'b1100; en = 1'b1;
    wait_q(2, 2, 20, "t4_reach_q2");
    req[2] = 1'b0;
    @(posedge clk); #1;
    chk("t4_abort_gnt", gnt, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_busy", busy, 0);
    @(posedge clk); #1;
    chk("t4_next_gnt", gnt, 4'b1000);
    chk("t4_next_owner", owner, 3);
    wait_done(3, 10, "t4_req3_done");
    req = '0;

    // Target 0 and target 31
    do_reset();
    set_tgt(0, 0); req = 4'b0001; en = 1'b1;
    @(posedge clk); #1;
    chk("t5_t0_gnt", gnt, 4'b0001);
    @(posedge clk); #1;
    chk("t5_t0_done", done, 4'b0001);
    req = '0;
    repeat (2) @(posedge clk);
    #2;
    set_tgt(1, 31); req = 4'b0010;
    wait_done(1, 45, "t5_t31_done");
    chk("t5_t31_q_at_done", q, 31);
    req = '0;
    @(posedge clk); #1;
    chk("t5_t31_q_after", q, 0);

    // Asynchronous reset mid-run, then requester 0 beats 2
    do_reset();
    set_tgt(2, 10); req = 4'b0100; en = 1'b1;
    wait_q(2, 3, 20, "t6_reach_q3");
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_q", q, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_tgt(0, 2); req = 4'b0101;
    @(posedge clk); #1;
    chk("t6_first_gnt", gnt, 4'b0001);
    chk("t6_first_owner", owner, 0);
    req = '0;
    repeat (3) @(posedge clk);

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            v = ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 6));
            set_tgt(i, v);
            req[i] = 1'b1;
          end
        end else if (done[i]) begin
          req[i] = $urandom_range(0, 1) != 0;
        end else if ($urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        v = int'($urandom_range(0, 31));
        set_tgt(int'($urandom_range(0, N - 1)), v);
      end
    end
    req = '0;
    repeat (40) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
